// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, branch flush, DM wait, debug halt/step.
// Optional perf counters (stall_cnt_o, flush_cnt_o) when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  ex_br_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  dbg_halt_i,
  input  logic                  dbg_step_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_write_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_write_o,
  output logic                  mem_wb_write_o,
  output logic                  mem_wb_bubble_o,
  output logic                  halted_o,
  output logic                  timeout_err_o
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt_o
  , output logic [CNT_W-1:0]    flush_cnt_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} state_t;

  state_t            state, state_next;
  logic              ret_halt, ret_halt_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall, load_use;
  logic              stall_evt, lu_evt, flush_evt;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign load_use  = ex_memread_i && (ex_rt_i != '0) &&
                     ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  // Outputs are gated by rst_n so they reach reset values without waiting for an edge.
  always_comb begin
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_write_o  = 1'b0;
    mem_wb_write_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    halted_o        = 1'b0;
    state_next      = state;
    ret_halt_next   = ret_halt;
    stall_evt       = 1'b0;
    lu_evt          = 1'b0;
    flush_evt       = 1'b0;
    if (rst_n) begin
      if (state == HALTED) begin
        halted_o = 1'b1;
        if (!dbg_halt_i)     state_next = RUN;
        else if (dbg_step_i) state_next = STEP;
      end else if (mem_stall) begin
        mem_wb_write_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
        stall_evt       = 1'b1;
        if (state != MEM_WAIT) begin
          state_next    = MEM_WAIT;
          ret_halt_next = (state == STEP);
        end
      end else begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        ex_mem_write_o = 1'b1;
        mem_wb_write_o = 1'b1;
        if (ex_br_taken_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          flush_evt     = 1'b1;
        end else if (load_use) begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_flush_o = 1'b1;
          lu_evt        = 1'b1;
        end
        // A wait entered from STEP always lands back in HALTED.
        unique case (state)
          STEP:     state_next = HALTED;
          MEM_WAIT: begin
            state_next    = (ret_halt || dbg_halt_i) ? HALTED : RUN;
            ret_halt_next = 1'b0;
          end
          default:  state_next = dbg_halt_i ? HALTED : RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      ret_halt      <= 1'b0;
      wait_cnt      <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      state    <= state_next;
      ret_halt <= ret_halt_next;
      if (stall_evt) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_LAST) timeout_err_o <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (state != HALTED) begin
      if ((stall_evt || lu_evt) && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_evt && (flush_cnt_o != '1))             flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
